// File: rtl/alu_operand_stage.sv
// Execute-side operand stage: one register slot between decode and ALU, with load-use stalls and flush.
// Define ALU_OPERAND_STAGE_FORWARDING_EN for EXMEM/MEMWB bypass; without it every RAW dependency stalls.
module alu_operand_stage #(
  parameter int size = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [size-1:0] RS1_DATA,
  input  logic [size-1:0] RS2_DATA,
  input  logic [size-1:0] IMM,
  input  logic [size-1:0] PC,
  input  logic [4:0]      RS1_ADDR,
  input  logic [4:0]      RS2_ADDR,
  input  logic [4:0]      RD_ADDR_IN,
  input  logic            ALUSRC,
  input  logic            AUIPC_SEL,
  input  logic [3:0]      ALU_CTRL_IN,
  input  logic            REG_WRITE_IN,
  input  logic            MEM_READ_IN,
  input  logic [4:0]      EXMEM_RD,
  input  logic            EXMEM_REGWRITE,
  input  logic [size-1:0] EXMEM_RESULT,
  input  logic [4:0]      MEMWB_RD,
  input  logic            MEMWB_REGWRITE,
  input  logic [size-1:0] MEMWB_RESULT,
  input  logic            FLUSH,
  input  logic            OUT_READY,
  output logic            OUT_VALID,
  output logic [size-1:0] X,
  output logic [size-1:0] Y,
  output logic [3:0]      CONTROL,
  output logic [size-1:0] STORE_DATA,
  output logic [4:0]      RD_ADDR_OUT,
  output logic            REG_WRITE_OUT,
  output logic            MEM_READ_OUT
);

  logic            valid_q, valid_d;
  logic [size-1:0] pc_q, pc_d;
  logic [size-1:0] imm_q, imm_d;
  logic [size-1:0] rs1_data_q, rs1_data_d;
  logic [size-1:0] rs2_data_q, rs2_data_d;
  logic [4:0]      rs1_addr_q, rs1_addr_d;
  logic [4:0]      rs2_addr_q, rs2_addr_d;
  logic [4:0]      rd_q, rd_d;
  logic            alusrc_q, alusrc_d;
  logic            auipc_q, auipc_d;
  logic [3:0]      ctrl_q, ctrl_d;
  logic            reg_write_q, reg_write_d;
  logic            mem_read_q, mem_read_d;

  logic            adv;
  logic            hazard;
  logic            load_use;
  logic [size-1:0] rs1_val;
  logic [size-1:0] rs2_val;

  // x0 is hardwired zero, so it can never be the producer of a dependency.
  function automatic logic raw_match(input logic [4:0] rd, input logic [4:0] a,
                                     input logic [4:0] b);
    return (rd != 5'd0) && ((rd == a) || (rd == b));
  endfunction

`ifdef ALU_OPERAND_STAGE_FORWARDING_EN
  function automatic logic [size-1:0] bypass(input logic [4:0] rs, input logic [size-1:0] own,
                                             input logic ex_we, input logic [4:0] ex_rd,
                                             input logic [size-1:0] ex_res,
                                             input logic wb_we, input logic [4:0] wb_rd,
                                             input logic [size-1:0] wb_res);
    if (ex_we && (ex_rd != 5'd0) && (ex_rd == rs)) return ex_res;
    if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) return wb_res;
    return own;
  endfunction

  always_comb begin
    rs1_val = bypass(rs1_addr_q, rs1_data_q, EXMEM_REGWRITE, EXMEM_RD, EXMEM_RESULT,
                     MEMWB_REGWRITE, MEMWB_RD, MEMWB_RESULT);
    rs2_val = bypass(rs2_addr_q, rs2_data_q, EXMEM_REGWRITE, EXMEM_RD, EXMEM_RESULT,
                     MEMWB_REGWRITE, MEMWB_RD, MEMWB_RESULT);
  end

  assign hazard = load_use;
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{EXMEM_RESULT, MEMWB_RESULT, rs1_addr_q, rs2_addr_q};

  always_comb begin
    rs1_val = rs1_data_q;
    rs2_val = rs2_data_q;
  end

  // No bypass network: any older in-flight writer of a source register must drain first.
  assign hazard = load_use
                || (valid_q && reg_write_q && raw_match(rd_q, RS1_ADDR, RS2_ADDR))
                || (EXMEM_REGWRITE && raw_match(EXMEM_RD, RS1_ADDR, RS2_ADDR))
                || (MEMWB_REGWRITE && raw_match(MEMWB_RD, RS1_ADDR, RS2_ADDR));
`endif

  assign load_use = valid_q && mem_read_q && raw_match(rd_q, RS1_ADDR, RS2_ADDR);
  assign adv      = !valid_q || OUT_READY;

  always_comb begin
    IN_READY    = adv && !hazard && !FLUSH;
    valid_d     = valid_q;
    pc_d        = pc_q;
    imm_d       = imm_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rd_d        = rd_q;
    alusrc_d    = alusrc_q;
    auipc_d     = auipc_q;
    ctrl_d      = ctrl_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    if (adv) begin
      if (IN_VALID && IN_READY) begin
        valid_d     = 1'b1;
        pc_d        = PC;
        imm_d       = IMM;
        rs1_data_d  = RS1_DATA;
        rs2_data_d  = RS2_DATA;
        rs1_addr_d  = RS1_ADDR;
        rs2_addr_d  = RS2_ADDR;
        rd_d        = RD_ADDR_IN;
        alusrc_d    = ALUSRC;
        auipc_d     = AUIPC_SEL;
        ctrl_d      = ALU_CTRL_IN;
        reg_write_d = REG_WRITE_IN;
        mem_read_d  = MEM_READ_IN;
      end else begin
        // Flush, bubble and idle all leave an empty slot with side effects disabled.
        valid_d     = 1'b0;
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      imm_q       <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_q        <= '0;
      alusrc_q    <= 1'b0;
      auipc_q     <= 1'b0;
      ctrl_q      <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      imm_q       <= imm_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rd_q        <= rd_d;
      alusrc_q    <= alusrc_d;
      auipc_q     <= auipc_d;
      ctrl_q      <= ctrl_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
    end
  end

  assign OUT_VALID     = valid_q;
  assign X             = auipc_q ? pc_q : rs1_val;
  assign Y             = alusrc_q ? imm_q : rs2_val;
  assign STORE_DATA    = rs2_val;
  assign CONTROL       = ctrl_q;
  assign RD_ADDR_OUT   = rd_q;
  assign REG_WRITE_OUT = reg_write_q;
  assign MEM_READ_OUT  = mem_read_q;

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 The block SHALL have parameter size, default 32, the datapath width.
REQ-002 The block SHALL have CLK  in  1  rising-edge clock; the block uses one clock.
REQ-003 The block SHALL have RST  in  1  reset, synchronous and active-high.
REQ-004 The block SHALL have IN_VALID in 1 and IN_READY out 1, the decode-side handshake.
REQ-005 The block SHALL have RS1_DATA, RS2_DATA, IMM, PC  in  size each, the decoded operands.
REQ-006 The block SHALL have RS1_ADDR, RS2_ADDR, RD_ADDR_IN  in  5 each, the register indices.
REQ-007 The block SHALL have ALUSRC in 1 (Y takes IMM) and AUIPC_SEL in 1 (X takes PC).
REQ-008 The block SHALL have ALU_CTRL_IN in 4, REG_WRITE_IN in 1 and MEM_READ_IN in 1.
REQ-009 The block SHALL have EXMEM_RD in 5, EXMEM_REGWRITE in 1, EXMEM_RESULT in size, MEMWB_RD in 5, MEMWB_REGWRITE in 1 and MEMWB_RESULT in size.
REQ-010 The block SHALL have FLUSH  in  1, the branch-redirect kill.
REQ-011 The block SHALL have OUT_READY  in  1, downstream accept.
REQ-012 The block SHALL have OUT_VALID out 1 and the ALU operand outputs X, Y out size and CONTROL out 4.
REQ-013 The block SHALL have STORE_DATA out size, RD_ADDR_OUT out 5, REG_WRITE_OUT out 1 and MEM_READ_OUT out 1.

Function
REQ-014 The stage SHALL be a single register slot: adv = !OUT_VALID || OUT_READY.
REQ-015 The stage SHALL compute hazard = OUT_VALID && MEM_READ_OUT && RD_ADDR_OUT!=0 && (RD_ADDR_OUT==RS1_ADDR || RD_ADDR_OUT==RS2_ADDR).
REQ-016 The stage SHALL drive IN_READY = adv && !hazard && !FLUSH, combinationally.
REQ-017 On an adv edge with FLUSH=1 the slot SHALL become empty (OUT_VALID=0), regardless of IN_VALID or hazard.
REQ-018 On an adv edge with hazard=1 and FLUSH=0 the slot SHALL load a bubble (OUT_VALID=0, REG_WRITE_OUT=0, MEM_READ_OUT=0) and leave the decode instruction unconsumed.
REQ-019 On an adv edge with IN_VALID && IN_READY the slot SHALL capture all inputs, and OUT_VALID=1 SHALL follow one cycle later (latency 1).
REQ-020 On an adv edge with IN_VALID=0 (no flush or hazard) the slot SHALL become empty.
REQ-021 When adv=0 all registered fields SHALL hold their values.
REQ-022 X SHALL be the registered PC if the registered AUIPC_SEL=1; otherwise it SHALL be the forwarded rs1 value.
REQ-023 Y SHALL be the registered IMM if the registered ALUSRC=1; otherwise it SHALL be the forwarded rs2 value.
REQ-024 STORE_DATA SHALL always be the forwarded rs2 value.
REQ-025 Forwarding SHALL be combinational on the registered values, with priority: EXMEM (REGWRITE && RD!=0 && RD==rs), then MEMWB (same rule), then the registered RSx_DATA.
REQ-026 Register x0 SHALL never be a forwarding or hazard source.
REQ-027 CONTROL SHALL equal the registered ALU_CTRL_IN, passed unmodified in the ALU encoding (0000 ADD, 0111 SUB, 0100 SLT, 1101 SLTU, 0010 AND, 0001 OR, 1001 XOR, 1000 SLL, 1010 SRL, 1110 SRA, 1011 BGE, 1111 BNE).
REQ-028 The output fields SHALL be meaningful only while OUT_VALID=1.

Reset
REQ-029 With RST=1 at a clock edge, OUT_VALID, REG_WRITE_OUT, MEM_READ_OUT, all data registers, RD_ADDR_OUT and CONTROL SHALL be 0.
REQ-030 RST SHALL take priority over FLUSH, hazard and capture, and SHALL discard any held instruction mid-stall.
REQ-031 IN_READY SHALL be 1 in the first cycle after reset release.

Configuration
REQ-032 The macro ALU_OPERAND_STAGE_FORWARDING_EN, when defined, SHALL enable REQ-025.
REQ-033 When ALU_OPERAND_STAGE_FORWARDING_EN is undefined, X, Y and STORE_DATA SHALL use the registered RSx_DATA directly.
REQ-034 When ALU_OPERAND_STAGE_FORWARDING_EN is undefined, hazard SHALL also assert for any RAW match (rd!=0, regwrite) against the slot, EXMEM or MEMWB.

Verification
REQ-035 Basic test: RS1_DATA=19, RS2_DATA=2, ALU_CTRL_IN=0000, OUT_READY=1 -> the next cycle gives OUT_VALID=1, X=19, Y=2, CONTROL=0000.
REQ-036 Forward priority test: slot rs1=x5 (data 0), EXMEM_RD=5/RESULT=22, MEMWB_RD=5/RESULT=99, both regwrite -> X=22; with EXMEM_REGWRITE=0 -> X=99; with rd=0 -> X=0.
REQ-037 Load-use test: slot holds load rd=x7, incoming RS2_ADDR=7 -> IN_READY=0, one bubble, then capture next cycle.
REQ-038 Backpressure test: OUT_READY=0 for 3 cycles -> X/Y/CONTROL stable, IN_READY=0; OUT_READY=1 -> the next instruction is captured.
REQ-039 Flush test: FLUSH=1 with IN_VALID=1 and a hazard active -> OUT_VALID=0 next cycle, input not consumed.
REQ-040 Reset test: RST pulsed during a stall -> all outputs 0 next cycle, IN_READY=1 after release.
